// File: rtl/apb_pkg.sv
// Shared types and constants for the APB interconnect and its address decoder.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } apb_state_e;

  localparam logic [1:0] FAULT_UNMAPPED = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT  = 2'b10;
  localparam logic [1:0] FAULT_SLVERR   = 2'b11;

  // Width of an index able to address n completers; never below 1 bit.
  function automatic int unsigned apb_idx_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((2 ** w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational base/mask address decoder; the lowest-index matching window wins.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned NUM_SLAVES = 5,
  parameter int unsigned IDX_W      = 3,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_SLAVES-1:0] hit_onehot_o,
  output logic [IDX_W-1:0]      hit_idx_o,
  output logic                  miss_o
);

  logic found;

  // Priority search from slave 0 upward so overlapping windows resolve to the lowest index.
  always_comb begin
    hit_onehot_o = '0;
    hit_idx_o    = '0;
    found        = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (!found &&
          ((addr_i & SLAVE_MASK[i*ADDR_WIDTH +: ADDR_WIDTH]) ==
           SLAVE_BASE[i*ADDR_WIDTH +: ADDR_WIDTH])) begin
        hit_onehot_o[i] = 1'b1;
        hit_idx_o       = IDX_W'(i);
        found           = 1'b1;
      end
    end
    miss_o = ~found;
  end

endmodule

// File: rtl/apb_interconnect.sv
// APB interconnect: one requester to NUM_SLAVES completers with registered transfer
// state, response timeout, unmapped-address error termination and sticky fault capture.
module apb_interconnect
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 5,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] SLAVE_MASK = '0,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TMO_WIDTH      = 8
) (
  input  logic                             pclk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            paddr,
  input  logic [DATA_WIDTH-1:0]            pdata,
  input  logic                             pwrite,
  input  logic [3:0]                       pstb,
  input  logic                             psel,
  input  logic                             penable,
  output logic [DATA_WIDTH-1:0]            prdata,
  output logic                             pready,
  output logic                             perr,
  output logic [NUM_SLAVES-1:0]            s_sel,
  output logic [NUM_SLAVES-1:0]            s_enable,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
  input  logic [NUM_SLAVES-1:0]            s_ready,
  input  logic [NUM_SLAVES-1:0]            s_perr,
  output logic                             fault_valid,
  output logic [ADDR_WIDTH-1:0]            fault_addr,
  output logic [1:0]                       fault_cause,
  input  logic                             fault_clear
);

  localparam int unsigned IDX_W = apb_idx_width(NUM_SLAVES);

  apb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [ADDR_WIDTH-1:0]  paddr_q, paddr_d;
  logic [TMO_WIDTH-1:0]   tmo_q, tmo_d;
  logic                   fault_valid_q;
  logic [ADDR_WIDTH-1:0]  fault_addr_q;
  logic [1:0]             fault_cause_q;

  logic [NUM_SLAVES-1:0]  hit_onehot;
  logic [IDX_W-1:0]       hit_idx;
  logic                   miss;

  logic [NUM_SLAVES-1:0]  sel_onehot;
  logic [DATA_WIDTH-1:0]  sel_rdata;
  logic                   sel_ready, sel_perr, timeout;
  logic                   fault_evt;
  logic [1:0]             fault_evt_cause;

  // Data, write and strobes are broadcast to the completers outside this block.
  logic unused_bcast;
  assign unused_bcast = ^{pdata, pwrite, pstb};

  apb_addr_decode #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_SLAVES (NUM_SLAVES),
    .IDX_W      (IDX_W),
    .SLAVE_BASE (SLAVE_BASE),
    .SLAVE_MASK (SLAVE_MASK)
  ) u_decode (
    .addr_i       (paddr),
    .hit_onehot_o (hit_onehot),
    .hit_idx_o    (hit_idx),
    .miss_o       (miss)
  );

  // Route the completer selected at setup back to the requester.
  always_comb begin
    sel_onehot = '0;
    sel_rdata  = '0;
    sel_ready  = 1'b0;
    sel_perr   = 1'b0;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (IDX_W'(i) == idx_q) begin
        sel_onehot[i] = 1'b1;
        sel_rdata     = s_rdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_ready     = s_ready[i];
        sel_perr      = s_perr[i];
      end
    end
    timeout = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_WIDTH'(TIMEOUT_CYCLES)) && !sel_ready;
  end

  // Transfer FSM, requester/completer handshake and fault event generation.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    paddr_d         = paddr_q;
    tmo_d           = tmo_q;
    s_sel           = '0;
    s_enable        = '0;
    prdata          = '0;
    pready          = 1'b0;
    perr            = 1'b0;
    fault_evt       = 1'b0;
    fault_evt_cause = FAULT_UNMAPPED;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          s_sel   = hit_onehot;
          idx_d   = hit_idx;
          paddr_d = paddr;
          tmo_d   = '0;
          state_d = miss ? ERROR : ACCESS;
        end
      end
      ACCESS: begin
        if (!psel) begin
          state_d = IDLE;
        end else begin
          s_sel = sel_onehot;
          if (timeout) begin
            pready = 1'b1;
            perr   = 1'b1;
          end else begin
            s_enable = penable ? sel_onehot : '0;
            pready   = sel_ready;
            perr     = sel_perr;
            prdata   = sel_rdata;
          end
          if (penable && (timeout || sel_ready)) begin
            state_d = IDLE;
            if (timeout) begin
              fault_evt       = 1'b1;
              fault_evt_cause = FAULT_TIMEOUT;
            end else if (sel_perr) begin
              fault_evt       = 1'b1;
              fault_evt_cause = FAULT_SLVERR;
            end
          end else if (penable && !sel_ready && (tmo_q != '1)) begin
            tmo_d = tmo_q + TMO_WIDTH'(1);
          end
        end
      end
      ERROR: begin
        if (!psel) begin
          state_d = IDLE;
        end else if (penable) begin
          pready          = 1'b1;
          perr            = 1'b1;
          state_d         = IDLE;
          fault_evt       = 1'b1;
          fault_evt_cause = FAULT_UNMAPPED;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      s_sel     = '0;
      s_enable  = '0;
      prdata    = '0;
      pready    = 1'b0;
      perr      = 1'b0;
      fault_evt = 1'b0;
    end
  end

  // State registers and first-fault-wins capture; a clear coinciding with a new fault keeps it.
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      paddr_q       <= '0;
      tmo_q         <= '0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= '0;
      fault_cause_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      paddr_q <= paddr_d;
      tmo_q   <= tmo_d;
      if (fault_evt && (!fault_valid_q || fault_clear)) begin
        fault_valid_q <= 1'b1;
        fault_addr_q  <= paddr_q;
        fault_cause_q <= fault_evt_cause;
      end else if (fault_clear) begin
        fault_valid_q <= 1'b0;
      end
    end
  end

  assign fault_valid = fault_valid_q;
  assign fault_addr  = fault_addr_q;
  assign fault_cause = fault_cause_q;

endmodule
